fpga_cfg_loader: RTL and testbench
==================================

// Module: fpga_cfg_loader
// PURPOSE
//  Hardware configuration loader for the fpga fabric (9 LUTs, 13 switch boxes).
//  Consumes a 32-bit word stream over a valid/ready handshake, hunts for a sync word,
//  and fills shadow LUT/switch-box configuration registers.
//  Commits shadows to the fabric atomically, and only when the trailing checksum matches.
//  Drives lt*.mem / sb*.configure in place of direct hierarchical writes.
// PARAMETERS
//  NUM_LUT    9             number of LUTs; each takes 2 stream words
//  LUT_BITS   33            LUT config width: {word_hi[0], word_lo[31:0]}
//  NUM_SB     13            number of switch boxes; each takes 1 stream word
//  SB_BITS    16            switch-box config width: word[15:0]
//  SYNC_WORD  32'hF0CAC0DE  frame start marker
// PORTS
//  clock       in   1                  rising-edge clock
//  reset       in   1                  asynchronous, active-high reset
//  cfg_start   in   1                  one-cycle pulse: begin, or restart, a load
//  cfg_data    in   32                 stream word
//  cfg_valid   in   1                  cfg_data valid
//  cfg_ready   out  1                  loader accepts a word this cycle
//  lut_cfg     out  NUM_LUT*LUT_BITS   committed LUT configs; LUT k at [k*LUT_BITS +: LUT_BITS]
//  sb_cfg      out  NUM_SB*SB_BITS     committed switch-box configs; SB j at [j*SB_BITS +: SB_BITS]
//  fabric_en   out  1                  committed config valid; fabric may run
//  cfg_done    out  1                  last load committed successfully
//  cfg_error   out  1                  last load failed its checksum
//  word_count  out  6                  payload words accepted since sync (0..31)
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including lut_cfg, sb_cfg and cfg_ready. Shadows cleared.
//  Beat: a word transfers on a rising edge when cfg_valid && cfg_ready.
//  cfg_ready = (state in SYNC/LUT_LO/LUT_HI/SB/CHECK) && !cfg_start (combinational).
//  Frame format: SYNC_WORD, then 31 payload words, then 1 checksum word.
//   Payload words 2k and 2k+1 carry LUT k (lo word, then hi word; only bit 0 of hi is used), k=0..8.
//   Payload words 18+j carry SB j (bits [15:0] used), j=0..12.
//   Checksum = XOR of all 31 full 32-bit payload words, unused bits included.
//  FSM:
//   IDLE   -> SYNC on cfg_start.
//   SYNC   -> LUT_LO on a beat == SYNC_WORD. Any other beat is discarded; stay in SYNC (hunt).
//   LUT_LO -> LUT_HI on a beat; stores shadow_lut[k][31:0].
//   LUT_HI -> stores shadow_lut[k][32]; then LUT_LO with k+1, or SB with j=0 when k==NUM_LUT-1.
//   SB     -> stores shadow_sb[j]; j+1. Goes to CHECK after j==NUM_SB-1.
//   CHECK  -> on a beat: DONE if the word equals the running XOR, else ERROR.
//   DONE/ERROR -> SYNC on cfg_start.
//  Running XOR and word_count clear on entry to SYNC; both update on every payload beat.
//  word_count saturates at 31.
//  Commit on the same edge that accepts a matching checksum:
//   lut_cfg/sb_cfg <= shadows; cfg_done=1; cfg_error=0; fabric_en=1.
//   So cfg_done is visible the first cycle after the checksum beat (latency 1).
//  Mismatch: cfg_error=1, cfg_done=0. lut_cfg/sb_cfg keep their previous committed values.
//   fabric_en stays 0.
//  cfg_start in any state except IDLE/DONE/ERROR: abort and go to SYNC.
//   Shadows are discarded (overwritten by the next frame).
//   cfg_done=0, cfg_error=0, fabric_en=0. lut_cfg/sb_cfg hold their last committed values.
//  cfg_start in IDLE/DONE/ERROR: same effects on flags and fabric_en.
//  cfg_start together with cfg_valid: start wins; the word is not consumed (cfg_ready=0).
//  cfg_valid stalls between beats are legal at any point. State holds; nothing advances.
//  reset mid-load: immediate return to reset values. No partial commit.
// TESTING
//  1 Sync, 31 words (LUT0 lo=32'h0000_00E8, hi=1; SB0=16'h0123), correct XOR checksum
//    -> lut_cfg[32:0]=33'h1_0000_00E8, sb_cfg[15:0]=16'h0123;
//       cfg_done=1 and fabric_en=1 one cycle after the checksum beat.
//  2 Same frame with checksum bit 0 flipped -> cfg_error=1, cfg_done=0, fabric_en=0;
//    lut_cfg/sb_cfg equal the values committed in test 1.
//  3 Words 32'hDEADBEEF and 32'h0 sent before SYNC_WORD -> both discarded;
//    word_count=0 until the first payload beat; load then succeeds.
//  4 cfg_start asserted after 10 payload words, then a full good frame
//    -> fabric_en=0 during the reload; final outputs match the second frame only.
//  5 Random cfg_valid gaps (~50% duty) across a full frame -> result identical to test 1;
//    word_count never exceeds 31.
//  6 reset asserted mid-SB section -> all outputs 0 within the reset cycle;
//    cfg_ready=0 until the next cfg_start.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//   Loads configuration for the fabric (9 LUTs, 13 switch boxes) from a 32-bit
//   valid/ready word stream. The loader first hunts for SYNC_WORD. It then
//   collects 31 payload words into shadow registers and checks a trailing XOR
//   checksum. When the checksum matches, the shadows are copied to the
//   committed outputs in a single edge.
// Ports
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   cfg_start       one-cycle pulse that begins, or restarts, a load
//   cfg_data/valid  stream word and its qualifier
//   cfg_ready       loader accepts a word this cycle (combinational)
//   lut_cfg         committed LUT configs, LUT k at [k*LUT_BITS +: LUT_BITS]
//   sb_cfg          committed switch-box configs, SB j at [j*SB_BITS +: SB_BITS]
//   fabric_en       committed config valid; fabric may run
//   cfg_done        last load committed
//   cfg_error       last load failed its checksum
//   word_count      payload words accepted since sync (saturates at 31)
module fpga_cfg_loader #(
  parameter int          NUM_LUT   = 9,
  parameter int          LUT_BITS  = 33,
  parameter int          NUM_SB    = 13,
  parameter int          SB_BITS   = 16,
  parameter logic [31:0] SYNC_WORD = 32'hF0CAC0DE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic [31:0]                 cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [NUM_LUT*LUT_BITS-1:0] lut_cfg,
  output logic [NUM_SB*SB_BITS-1:0]   sb_cfg,
  output logic                        fabric_en,
  output logic                        cfg_done,
  output logic                        cfg_error,
  output logic [5:0]                  word_count
);

  localparam int IDX_W = $clog2((NUM_SB > NUM_LUT) ? NUM_SB : NUM_LUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LUT_LO, S_LUT_HI, S_SB, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;        // LUT k or SB j
  logic [31:0]                 xor_q, xor_d;        // running payload checksum
  logic [5:0]                  word_count_q, word_count_d;
  logic [LUT_BITS-1:0]         shadow_lut_q [NUM_LUT];
  logic [LUT_BITS-1:0]         shadow_lut_d [NUM_LUT];
  logic [SB_BITS-1:0]          shadow_sb_q  [NUM_SB];
  logic [SB_BITS-1:0]          shadow_sb_d  [NUM_SB];
  logic [NUM_LUT*LUT_BITS-1:0] lut_cfg_q, lut_cfg_d;
  logic [NUM_SB*SB_BITS-1:0]   sb_cfg_q, sb_cfg_d;
  logic                        fabric_en_q, fabric_en_d;
  logic                        cfg_done_q, cfg_done_d;
  logic                        cfg_error_q, cfg_error_d;
  logic                        beat;

  // A pending start always wins over a word, so the word is never consumed
  // in the same cycle as a restart.
  always_comb begin
    cfg_ready = (state_q inside {S_SYNC, S_LUT_LO, S_LUT_HI, S_SB, S_CHECK})
                && !cfg_start;
  end

  assign beat = cfg_valid && cfg_ready;

  always_comb begin
    // NOTE: every variable gets a hold-value default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    word_count_d = word_count_q;
    shadow_lut_d = shadow_lut_q;
    shadow_sb_d  = shadow_sb_q;
    lut_cfg_d    = lut_cfg_q;
    sb_cfg_d     = sb_cfg_q;
    fabric_en_d  = fabric_en_q;
    cfg_done_d   = cfg_done_q;
    cfg_error_d  = cfg_error_q;

    if (cfg_start) begin
      // A start or abort in any state leaves the committed configs untouched.
      // The stale shadows are overwritten by the next frame.
      state_d      = S_SYNC;
      xor_d        = '0;
      word_count_d = '0;
      fabric_en_d  = 1'b0;
      cfg_done_d   = 1'b0;
      cfg_error_d  = 1'b0;
    end else if (beat) begin
      if (state_q inside {S_LUT_LO, S_LUT_HI, S_SB}) begin
        xor_d = xor_q ^ cfg_data;
        if (word_count_q != 6'd31) word_count_d = word_count_q + 6'd1;
      end
      unique case (state_q)
        S_SYNC: begin
          if (cfg_data == SYNC_WORD) begin
            state_d = S_LUT_LO;
            idx_d   = '0;
          end
        end
        S_LUT_LO: begin
          shadow_lut_d[idx_q][31:0] = cfg_data;
          state_d = S_LUT_HI;
        end
        S_LUT_HI: begin
          shadow_lut_d[idx_q][LUT_BITS-1] = cfg_data[0];
          if (idx_q == IDX_W'(NUM_LUT - 1)) begin
            state_d = S_SB;
            idx_d   = '0;
          end else begin
            state_d = S_LUT_LO;
            idx_d   = idx_q + 1'b1;
          end
        end
        S_SB: begin
          shadow_sb_d[idx_q] = cfg_data[SB_BITS-1:0];
          if (idx_q == IDX_W'(NUM_SB - 1)) state_d = S_CHECK;
          else                             idx_d   = idx_q + 1'b1;
        end
        S_CHECK: begin
          if (cfg_data == xor_q) begin
            state_d     = S_DONE;
            fabric_en_d = 1'b1;
            cfg_done_d  = 1'b1;
            cfg_error_d = 1'b0;
            for (int k = 0; k < NUM_LUT; k++)
              lut_cfg_d[k*LUT_BITS +: LUT_BITS] = shadow_lut_q[k];
            for (int j = 0; j < NUM_SB; j++)
              sb_cfg_d[j*SB_BITS +: SB_BITS] = shadow_sb_q[j];
          end else begin
            state_d     = S_ERROR;
            fabric_en_d = 1'b0;
            cfg_done_d  = 1'b0;
            cfg_error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      xor_q        <= '0;
      word_count_q <= '0;
      lut_cfg_q    <= '0;
      sb_cfg_q     <= '0;
      fabric_en_q  <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_error_q  <= 1'b0;
      // NOTE: the shadow arrays are reset explicitly, so a reset during a load
      // leaves no partial frame behind. These are flops, not a RAM, so the cost
      // is only reset fan-out.
      for (int k = 0; k < NUM_LUT; k++) shadow_lut_q[k] <= '0;
      for (int j = 0; j < NUM_SB; j++)  shadow_sb_q[j]  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      word_count_q <= word_count_d;
      lut_cfg_q    <= lut_cfg_d;
      sb_cfg_q     <= sb_cfg_d;
      fabric_en_q  <= fabric_en_d;
      cfg_done_q   <= cfg_done_d;
      cfg_error_q  <= cfg_error_d;
      shadow_lut_q <= shadow_lut_d;
      shadow_sb_q  <= shadow_sb_d;
    end
  end

  assign lut_cfg    = lut_cfg_q;
  assign sb_cfg     = sb_cfg_q;
  assign fabric_en  = fabric_en_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_error  = cfg_error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader.
// The reference model tracks the loader as a position within a frame:
// hunting, payload index n, or the checksum slot. The expected LUT and SB
// values come from the raw payload word list only when a frame completes.
// Inputs are driven 1 time unit after each rising edge, and all outputs are
// compared at the falling edge.
module tb_fpga_cfg_loader;

  localparam int          NUM_LUT  = 9;
  localparam int          LUT_BITS = 33;
  localparam int          NUM_SB   = 13;
  localparam int          SB_BITS  = 16;
  localparam logic [31:0] SYNC     = 32'hF0CAC0DE;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        cfg_start = 1'b0;
  logic [31:0]                 cfg_data = '0;
  logic                        cfg_valid = 1'b0;
  logic                        cfg_ready;
  logic [NUM_LUT*LUT_BITS-1:0] lut_cfg;
  logic [NUM_SB*SB_BITS-1:0]   sb_cfg;
  logic                        fabric_en, cfg_done, cfg_error;
  logic [5:0]                  word_count;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  fpga_cfg_loader dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .lut_cfg(lut_cfg),
    .sb_cfg(sb_cfg), .fabric_en(fabric_en), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [319:0] act,
                       input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_active;          // a load is in progress (hunting or in frame)
  logic        m_synced;          // sync word seen
  int          m_n;               // payload words received
  logic [31:0] m_words [31];
  logic [32:0] m_lut   [NUM_LUT];
  logic [15:0] m_sb    [NUM_SB];
  logic        m_done, m_err, m_fen;

  function automatic logic [31:0] xor_all();
    logic [31:0] x = '0;
    for (int i = 0; i < 31; i++) x ^= m_words[i];
    return x;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_synced <= 1'b0; m_n <= 0;
      m_done <= 1'b0; m_err <= 1'b0; m_fen <= 1'b0;
      for (int k = 0; k < NUM_LUT; k++) m_lut[k] <= '0;
      for (int j = 0; j < NUM_SB; j++)  m_sb[j]  <= '0;
    end else if (cfg_start) begin
      m_active <= 1'b1; m_synced <= 1'b0; m_n <= 0;
      m_done <= 1'b0; m_err <= 1'b0; m_fen <= 1'b0;
    end else if (cfg_valid && m_active) begin
      if (!m_synced) begin
        if (cfg_data == SYNC) m_synced <= 1'b1;
      end else if (m_n < 31) begin
        m_words[m_n] <= cfg_data;
        m_n <= m_n + 1;
      end else begin
        m_active <= 1'b0;
        if (cfg_data == xor_all()) begin
          m_done <= 1'b1; m_err <= 1'b0; m_fen <= 1'b1;
          for (int k = 0; k < NUM_LUT; k++)
            m_lut[k] <= {m_words[2*k+1][0], m_words[2*k]};
          for (int j = 0; j < NUM_SB; j++)
            m_sb[j] <= m_words[18+j][15:0];
        end else begin
          m_done <= 1'b0; m_err <= 1'b1; m_fen <= 1'b0;
        end
      end
    end
  end

  logic [NUM_LUT*LUT_BITS-1:0] exp_lut;
  logic [NUM_SB*SB_BITS-1:0]   exp_sb;
  always_comb begin
    exp_lut = '0;
    exp_sb  = '0;
    for (int k = 0; k < NUM_LUT; k++) exp_lut[k*LUT_BITS +: LUT_BITS] = m_lut[k];
    for (int j = 0; j < NUM_SB; j++)  exp_sb[j*SB_BITS +: SB_BITS]    = m_sb[j];
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cfg_ready",  cfg_ready,  m_active && !cfg_start);
      check("lut_cfg",    lut_cfg,    exp_lut);
      check("sb_cfg",     sb_cfg,     exp_sb);
      check("fabric_en",  fabric_en,  m_fen);
      check("cfg_done",   cfg_done,   m_done);
      check("cfg_error",  cfg_error,  m_err);
      check("word_count", word_count, 6'(m_n));
      check("wc_max",     word_count <= 6'd31, 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pay  [31];
  logic [31:0] pay1 [31];
  logic [31:0] chk;

  task automatic make_frame();
    for (int i = 0; i < 31; i++) pay[i] = $urandom;
    chk = '0;
    for (int i = 0; i < 31; i++) chk ^= pay[i];
  endtask

  task automatic fix_checksum();
    chk = '0;
    for (int i = 0; i < 31; i++) chk ^= pay[i];
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic start_pulse(input bit with_valid);
    cfg_start = 1'b1;
    cfg_valid = with_valid;
    cfg_data  = SYNC;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int gap_pct);
    for (int g = 0; g < 8 && $urandom_range(1, 100) <= gap_pct; g++) begin
      cfg_data = $urandom;
      @(posedge clock); #1;
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    @(posedge clock); #1;
    cfg_valid = 1'b0;
    cfg_data  = $urandom;
  endtask

  task automatic send_frame(input int gap_pct, input int n_pay, input logic [31:0] flip);
    send(SYNC, gap_pct);
    for (int i = 0; i < n_pay; i++) send(pay[i], gap_pct);
    if (n_pay == 31) send(chk ^ flip, gap_pct);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 cmp_en = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("reset lut_cfg", lut_cfg, '0);
    check("reset sb_cfg", sb_cfg, '0);
    check("reset ready", cfg_ready, 1'b0);
    check("reset flags", {fabric_en, cfg_done, cfg_error, word_count}, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    // Test 1: a known good frame.
    make_frame();
    pay[0] = 32'h0000_00E8; pay[1] = 32'h0000_0001; pay[18] = 32'h0000_0123;
    fix_checksum();
    pay1 = pay;
    start_pulse(1'b0);
    send_frame(0, 31, 32'h0);
    @(negedge clock);
    check("t1 done", {cfg_done, fabric_en, cfg_error}, 3'b110);
    check("t1 lut0", lut_cfg[32:0], 33'h1_0000_00E8);
    check("t1 sb0", sb_cfg[15:0], 16'h0123);
    @(posedge clock); #1;
    idle(2);

    // Test 2: same frame with a bad checksum.
    start_pulse(1'b0);
    send_frame(0, 31, 32'h1);
    @(negedge clock);
    check("t2 flags", {cfg_done, fabric_en, cfg_error}, 3'b001);
    check("t2 lut0 kept", lut_cfg[32:0], 33'h1_0000_00E8);
    check("t2 sb0 kept", sb_cfg[15:0], 16'h0123);
    @(posedge clock); #1;

    // Test 3: junk words ahead of the sync word.
    make_frame();
    start_pulse(1'b0);
    send(32'hDEADBEEF, 0);
    send(32'h0, 0);
    @(negedge clock);
    check("t3 wc after junk", word_count, 6'd0);
    @(posedge clock); #1;
    send_frame(0, 31, 32'h0);
    @(negedge clock);
    check("t3 done", cfg_done, 1'b1);
    @(posedge clock); #1;

    // Test 4: abort after 10 payload words, with a word offered alongside the start.
    make_frame();
    start_pulse(1'b0);
    send_frame(0, 10, 32'h0);
    start_pulse(1'b1);
    @(negedge clock);
    check("t4 fabric off", fabric_en, 1'b0);
    check("t4 wc cleared", word_count, 6'd0);
    @(posedge clock); #1;
    make_frame();
    send_frame(0, 31, 32'h0);
    @(negedge clock);
    check("t4 done", cfg_done, 1'b1);
    @(posedge clock); #1;

    // Test 5: the test 1 frame with random valid gaps.
    pay = pay1;
    fix_checksum();
    start_pulse(1'b0);
    send_frame(50, 31, 32'h0);
    @(negedge clock);
    check("t5 done", {cfg_done, fabric_en}, 2'b11);
    check("t5 lut0", lut_cfg[32:0], 33'h1_0000_00E8);
    check("t5 sb0", sb_cfg[15:0], 16'h0123);
    @(posedge clock); #1;

    // Test 6: reset in the middle of the SB section.
    make_frame();
    start_pulse(1'b0);
    send_frame(0, 25, 32'h0);
    reset = 1'b1;
    #1;
    check("t6 lut zero", lut_cfg, '0);
    check("t6 sb zero", sb_cfg, '0);
    check("t6 flags zero", {cfg_ready, fabric_en, cfg_done, cfg_error, word_count}, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(3);
    @(negedge clock);
    check("t6 ready idle", cfg_ready, 1'b0);
    @(posedge clock); #1;
    make_frame();
    start_pulse(1'b0);
    send_frame(30, 31, 32'h0);
    idle(2);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
